// File: rtl/pwm_dir_capture.sv
// Receive-side decoder for the direction PWM link: measures high time and period
// of each frame, validates it and recovers the 8-bit direction command.
module pwm_dir_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned MIN_HIGH    = 229,
  parameter int unsigned MAX_HIGH    = 371,
  parameter int unsigned PERIOD      = 607,
  parameter int unsigned PERIOD_TOL  = 8,
  parameter int unsigned TIMEOUT     = 2048,
  parameter logic [7:0]  RST_DATA    = 8'd150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_PRE  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   P_MIN   = (CNT_W+1)'(PERIOD - PERIOD_TOL);
  localparam logic [CNT_W:0]   P_MAX   = (CNT_W+1)'(PERIOD + PERIOD_TOL);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s, pwm_q, rise, fall;
  logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d, to_cnt_q, to_cnt_d;
  logic                   to_hit, frame_done, accept;
  logic [CNT_W:0]         period;
  logic [7:0]             data_q;
  logic                   valid_q, err_q, tmo_q;

  // History flops reset high so a line already high at reset is not seen as a rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      pwm_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_q  <= pwm_s;
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_q;
  assign fall  = ~pwm_s & pwm_q;

  // Any edge clears the idle counter, so an edge always beats a coincident timeout.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_hit   = 1'b0;
    if (rise || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LIM) begin
      to_cnt_d = to_cnt_q + 1'b1;
      to_hit   = (to_cnt_q == TO_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (to_hit) begin
      state_d  = IDLE;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            hi_cnt_d = CNT_W'(1);
            lo_cnt_d = '0;
            state_d  = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            lo_cnt_d = CNT_W'(1);
            state_d  = LOW;
          end else if (pwm_s && hi_cnt_q != CNT_MAX) begin
            hi_cnt_d = hi_cnt_q + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            hi_cnt_d = CNT_W'(1);
            lo_cnt_d = '0;
            state_d  = HIGH;
          end else if (!pwm_s && lo_cnt_q != CNT_MAX) begin
            lo_cnt_d = lo_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    period     = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
    frame_done = (state_q == LOW) && rise && !to_hit;
    accept     = (hi_cnt_q >= HI_MIN) && (hi_cnt_q <= HI_MAX) &&
                 (period >= P_MIN) && (period <= P_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= RST_DATA;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      valid_q <= frame_done && accept;
      err_q   <= frame_done && !accept;
      if (to_hit) begin
        data_q <= RST_DATA;
        tmo_q  <= 1'b1;
      end else if (frame_done && accept) begin
        data_q <= hi_cnt_q[8:1];
        tmo_q  <= 1'b0;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_pwm_dir_capture.sv
// Randomised and directed bench for pwm_dir_capture; an event-level frame model
// predicts every output on every cycle.
module tb_pwm_dir_capture;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 2048;
  // Output appears after the sampling edge, the remaining sync stages and the output register.
  localparam int LAT         = SYNC_STAGES + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] data_out;
  logic       data_valid, frame_err, timeout;

  always #5 clk = ~clk;

  pwm_dir_capture #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (12),
    .MIN_HIGH   (229),
    .MAX_HIGH   (371),
    .PERIOD     (607),
    .PERIOD_TOL (8),
    .TIMEOUT    (TIMEOUT),
    .RST_DATA   (8'd150)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef enum {EV_ACC, EV_REJ, EV_TMO} ev_kind_e;
  typedef struct {
    int         at;
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  ev_t evq[$];

  // Frame-level model state, owned by the stimulus process.
  bit line_lvl;
  bit in_frame;
  int cur_h, cur_l;

  // Drive pwm_in to v for n ticks (change lands just after a rising edge).
  task automatic seg(input bit v, input int n);
    int c;
    bit is_edge;
    int p;
    c = cyc;
    is_edge = (v != line_lvl);
    if (v && is_edge) begin
      if (in_frame && cur_l > 0) begin
        p = cur_h + cur_l - 607;
        if (cur_h >= 229 && cur_h <= 371 && p >= -8 && p <= 8)
          evq.push_back('{c + LAT, EV_ACC, 8'(cur_h / 2)});
        else
          evq.push_back('{c + LAT, EV_REJ, 8'd0});
      end
      in_frame = 1'b1;
      cur_h = n;
      cur_l = 0;
    end else if (v) begin
      cur_h += n;
    end else if (is_edge) begin
      cur_l = n;
    end else begin
      cur_l += n;
    end
    // A level held longer than TIMEOUT after its edge loses the link.
    if (is_edge && n > TIMEOUT) begin
      evq.push_back('{c + LAT + TIMEOUT, EV_TMO, 8'd150});
      in_frame = 1'b0;
    end
    line_lvl = v;
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int h, input int l);
    seg(1'b1, h);
    seg(1'b0, l);
  endtask

  logic [7:0] exp_data = 8'd150;
  bit         exp_tmo  = 1'b0;
  bit         exp_val, exp_err;
  ev_t        cur_ev;

  always @(negedge clk) begin
    exp_val = 1'b0;
    exp_err = 1'b0;
    if (!rst) begin
      evq.delete();
      exp_data = 8'd150;
      exp_tmo  = 1'b0;
    end else if (evq.size() > 0 && evq[0].at == cyc) begin
      cur_ev = evq.pop_front();
      case (cur_ev.kind)
        EV_ACC: begin exp_val = 1'b1; exp_data = cur_ev.data; exp_tmo = 1'b0; end
        EV_REJ: exp_err = 1'b1;
        default: begin exp_tmo = 1'b1; exp_data = 8'd150; end
      endcase
    end
    check_eq("data_valid", 32'(data_valid), 32'(exp_val));
    check_eq("frame_err",  32'(frame_err),  32'(exp_err));
    check_eq("data_out",   32'(data_out),   32'(exp_data));
    check_eq("timeout",    32'(timeout),    32'(exp_tmo));
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    pwm_in   = 1'b1;
    line_lvl = 1'b1;
    in_frame = 1'b0;
    cur_h    = 0;
    cur_l    = 0;
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;

    // Line high across reset: the partial first high must be ignored.
    seg(1'b1, 300);
    seg(1'b0, 307);
    frame(300, 307);
    frame(300, 307);

    // Legal boundaries of the high window.
    frame(229, 378);
    frame(371, 236);
    frame(301, 306);

    // High time just outside the window.
    frame(228, 379);
    frame(372, 235);

    // Period tolerance edge: 616 rejected, 615 accepted.
    frame(300, 316);
    frame(300, 315);

    // Good frame carrying 180, then line lost low.
    frame(360, 247);
    frame(300, 2100);
    frame(320, 287);
    frame(300, 307);

    // Low held exactly TIMEOUT: the edge wins, frame rejected, no timeout.
    frame(300, TIMEOUT);
    frame(360, 247);

    // Reset in the middle of a high phase.
    seg(1'b1, 100);
    rst = 1'b0;
    #1;
    check_eq("rst_data_out", 32'(data_out), 32'd150);
    check_eq("rst_valid",    32'(data_valid), 32'd0);
    check_eq("rst_err",      32'(frame_err), 32'd0);
    check_eq("rst_timeout",  32'(timeout), 32'd0);
    in_frame = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    seg(1'b1, 200);
    seg(1'b0, 307);
    frame(300, 307);
    frame(340, 267);

    for (int i = 0; i < 40; i++) begin
      int h, l;
      h = int'($urandom_range(200, 400));
      l = 607 - h + int'($urandom_range(0, 40)) - 20;
      frame(h, l);
    end

    seg(1'b1, LAT + 10);
    check_eq("events_drained", 32'(evq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
